// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: shared types and constants for the LZRW1 item parser.
//   parser_state_t : parser FSM states
//   item_t         : one decoded item (control bit + 16-bit payload)
//   LIT_PAD        : upper byte of a literal item
//   DEFAULT_CW_BITS: default number of items per control word
package lzrw1_pkg;

  typedef enum logic [2:0] {
    CW_LOAD,
    ITEM_B0,
    ITEM_B1,
    PRESENT,
    GAP,
    DONE
  } parser_state_t;

  typedef struct packed {
    logic        ctrl;
    logic [15:0] data;
  } item_t;

  localparam logic [7:0]  LIT_PAD         = 8'h00;
  localparam int unsigned DEFAULT_CW_BITS = 16;

endpackage

// File: rtl/lzrw1_item_parser.sv
// lzrw1_item_parser: splits a raw LZRW1 compressed byte stream into 16-bit
// items (literal = {00, lit}, copy = {b0, b1}) with their control bit, and
// strips the little-endian control words that govern CW_BITS items each.
//
// Ports:
//   clock, reset (async, active-low)
//   byte_in/byte_in_valid/byte_in_last/byte_in_ready : input byte stream
//   data_out/control_word_out/data_out_valid         : item to decompressor
//   decompressor_busy : item accepted only while low
//   parse_done        : one-cycle pulse once the stream has been consumed
//   format_error      : sticky, stream ended inside a copy item
//   literal_count/copy_count : accepted-item counters, present only when
//                              LZRW1_PARSER_STATS_EN is defined
module lzrw1_item_parser
  import lzrw1_pkg::*;
#(
  parameter int unsigned CW_BITS = DEFAULT_CW_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  input  logic        byte_in_last,
  output logic [15:0] data_out,
  output logic        control_word_out,
  output logic        data_out_valid,
  input  logic        decompressor_busy,
  output logic        parse_done,
  output logic        format_error
`ifdef LZRW1_PARSER_STATS_EN
  ,
  output logic [31:0] literal_count,
  output logic [31:0] copy_count
`endif
);

  localparam int unsigned CW_BYTES = CW_BITS / 8;
  localparam int unsigned BIT_W    = $clog2(CW_BITS);
  localparam logic [1:0]       CNT_LAST = 2'(CW_BYTES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CW_BITS - 1);

  parser_state_t      state;
  logic [CW_BITS-1:0] cw_sr;
  logic [CW_BITS-1:0] cw_load_next;
  logic [1:0]         cw_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic               last_flag;
  item_t              item_q;

  // Control word bytes arrive LSB first: each new byte enters at the top and
  // everything shifts down, so after CW_BYTES loads the first byte is cw[7:0].
  // The item bit for the current position is always cw_sr[0].
  always_comb begin
    logic [CW_BITS+7:0] cat;
    cat          = {byte_in, cw_sr};
    cw_load_next = cat[CW_BITS+7:8];
  end

  // Gated by reset so the handshake is low while reset is held.
  assign byte_in_ready    = reset && (state == CW_LOAD || state == ITEM_B0 || state == ITEM_B1);
  assign data_out_valid   = (state == PRESENT);
  assign parse_done       = (state == DONE);
  assign data_out         = item_q.data;
  assign control_word_out = item_q.ctrl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= CW_LOAD;
      cw_sr        <= '0;
      cw_cnt       <= '0;
      bit_idx      <= '0;
      last_flag    <= 1'b0;
      item_q       <= '0;
      format_error <= 1'b0;
    end else begin
      case (state)
        CW_LOAD: begin
          if (byte_in_valid) begin
            cw_sr <= cw_load_next;
            if (byte_in_last) begin
              cw_cnt <= '0;
              state  <= DONE;
            end else if (cw_cnt == CNT_LAST) begin
              cw_cnt  <= '0;
              bit_idx <= '0;
              state   <= ITEM_B0;
            end else begin
              cw_cnt <= cw_cnt + 2'd1;
            end
          end
        end
        ITEM_B0: begin
          if (byte_in_valid) begin
            if (!cw_sr[0]) begin
              item_q    <= '{ctrl: 1'b0, data: {LIT_PAD, byte_in}};
              last_flag <= byte_in_last;
              state     <= PRESENT;
            end else if (byte_in_last) begin
              format_error <= 1'b1;
              state        <= DONE;
            end else begin
              item_q.data[15:8] <= byte_in;
              state             <= ITEM_B1;
            end
          end
        end
        ITEM_B1: begin
          if (byte_in_valid) begin
            item_q.data[7:0] <= byte_in;
            item_q.ctrl      <= 1'b1;
            last_flag        <= byte_in_last;
            state            <= PRESENT;
          end
        end
        PRESENT: begin
          if (!decompressor_busy) state <= GAP;
        end
        GAP: begin
          cw_sr <= cw_sr >> 1;
          if (bit_idx == BIT_LAST) bit_idx <= '0;
          else                     bit_idx <= bit_idx + BIT_W'(1);
          if (last_flag)                state <= DONE;
          else if (bit_idx == BIT_LAST) state <= CW_LOAD;
          else                          state <= ITEM_B0;
        end
        DONE: begin
          last_flag <= 1'b0;
          bit_idx   <= '0;
          cw_cnt    <= '0;
          state     <= CW_LOAD;
        end
        default: state <= CW_LOAD;
      endcase
    end
  end

`ifdef LZRW1_PARSER_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      literal_count <= '0;
      copy_count    <= '0;
    end else if (state == PRESENT && !decompressor_busy) begin
      if (item_q.ctrl) begin
        if (copy_count != '1) copy_count <= copy_count + 32'd1;
      end else begin
        if (literal_count != '1) literal_count <= literal_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lzrw1_item_parser.sv
// Scoreboard bench for lzrw1_item_parser: streams are built from item lists,
// expected items are queued at build time, and a monitor checks every
// accepted item, the post-accept gap, stall stability and parse_done.
module tb_lzrw1_item_parser;
  import lzrw1_pkg::*;

  localparam int unsigned CWB     = 16;
  localparam int unsigned CYC_MAX = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_ready;
  logic        byte_in_last = 1'b0;
  logic [15:0] data_out;
  logic        control_word_out;
  logic        data_out_valid;
  logic        decompressor_busy = 1'b0;
  logic        parse_done;
  logic        format_error;
`ifdef LZRW1_PARSER_STATS_EN
  logic [31:0] literal_count;
  logic [31:0] copy_count;
`endif

  lzrw1_item_parser #(.CW_BITS(CWB)) dut (
    .clock(clock), .reset(reset),
    .byte_in(byte_in), .byte_in_valid(byte_in_valid),
    .byte_in_ready(byte_in_ready), .byte_in_last(byte_in_last),
    .data_out(data_out), .control_word_out(control_word_out),
    .data_out_valid(data_out_valid), .decompressor_busy(decompressor_busy),
    .parse_done(parse_done), .format_error(format_error)
`ifdef LZRW1_PARSER_STATS_EN
    , .literal_count(literal_count), .copy_count(copy_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  item_t       exp_q[$];
  logic [8:0]  sb[$];
  bit          it_typ[$];
  logic [7:0]  it_b0[$];
  logic [7:0]  it_b1[$];
  int          done_cnt = 0;
  int          done_exp = 0;
  logic        err_exp  = 1'b0;
  int unsigned lit_exp  = 0;
  int unsigned cp_exp   = 0;
  bit          rnd_busy = 1'b0;
  bit          rnd_gap  = 1'b0;
  bit          busy_hold = 1'b0;
  bit          acc_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Downstream model: busy for two cycles after every accept, plus optional
  // random busy and a forced hold.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge clock); #1;
      if (acc_pulse) begin acc_pulse = 1'b0; bcnt = 2; end
      if (!reset) begin decompressor_busy = 1'b0; bcnt = 0; end
      else if (busy_hold) decompressor_busy = 1'b1;
      else if (bcnt > 0) begin decompressor_busy = 1'b1; bcnt--; end
      else decompressor_busy = rnd_busy ? ($urandom % 3 == 0) : 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          gap_due, prev_v, pd_prev;
    logic [16:0] prev;
    item_t       e;
    gap_due = 0; prev_v = 0; pd_prev = 0; prev = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        gap_due = 0; prev_v = 0; pd_prev = 0;
        continue;
      end
      if (gap_due) begin
        chk("gap_after_accept", 32'(data_out_valid), 32'd0);
        gap_due = 0;
      end
      if (data_out_valid) begin
        chk("ready_low_in_present", 32'(byte_in_ready), 32'd0);
        if (prev_v) chk("held_item_stable", 32'({control_word_out, data_out}), 32'(prev));
        prev   = {control_word_out, data_out};
        prev_v = decompressor_busy;
        if (!decompressor_busy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_item actual=%h required=none", {control_word_out, data_out});
          end else begin
            e = exp_q.pop_front();
            checks--;
            chk("item", 32'({control_word_out, data_out}), 32'({e.ctrl, e.data}));
            if (e.ctrl) cp_exp++; else lit_exp++;
          end
          gap_due   = 1;
          acc_pulse = 1'b1;
        end
      end else begin
        prev_v = 0;
      end
      if (parse_done) begin
        if (pd_prev) chk("parse_done_one_cycle", 32'd1, 32'd0);
        done_cnt++;
      end
      pd_prev = parse_done;
    end
  end

  // Returns at posedge+1 with the byte consumed.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int unsigned g;
    g = rnd_gap ? $urandom % 3 : 0;
    repeat (g) begin @(posedge clock); #1; end
    byte_in = b; byte_in_last = l; byte_in_valid = 1'b1;
    for (int c = 0; c < CYC_MAX; c++) begin
      @(negedge clock);
      if (byte_in_ready) begin
        @(posedge clock); #1;
        byte_in_valid = 1'b0; byte_in_last = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL byte_accept_timeout actual=stalled required=accepted");
    byte_in_valid = 1'b0; byte_in_last = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b, input logic l);
    sb.push_back({l, b});
  endtask

  // mode 0: last on final item byte; 1: ends with cw_k control bytes;
  // 2: final entry is a copy truncated after b0.
  task automatic build(input int mode, input int cw_k, input bit rnd_fill);
    int          total;
    logic [31:0] cw;
    bit          lst;
    item_t       it;
    total = it_typ.size();
    for (int i = 0; i < total; i++) begin
      if (i % CWB == 0) begin
        cw = rnd_fill ? $urandom : 32'd0;
        for (int j = 0; j < CWB; j++) if (i + j < total) cw[j] = it_typ[i + j];
        for (int k = 0; k < CWB / 8; k++) push_b(cw[8*k +: 8], 1'b0);
      end
      lst = (i == total - 1);
      if (mode == 2 && lst) begin
        push_b(it_b0[i], 1'b1);
      end else if (it_typ[i]) begin
        push_b(it_b0[i], 1'b0);
        push_b(it_b1[i], mode == 0 && lst);
        it.ctrl = 1'b1; it.data = {it_b0[i], it_b1[i]};
        exp_q.push_back(it);
      end else begin
        push_b(it_b0[i], mode == 0 && lst);
        it.ctrl = 1'b0; it.data = {8'h00, it_b0[i]};
        exp_q.push_back(it);
      end
    end
    if (mode == 1) begin
      cw = $urandom;
      for (int k = 0; k < cw_k; k++) push_b(cw[8*k +: 8], k == cw_k - 1);
    end
    done_exp++;
    if (mode == 2) err_exp = 1'b1;
    it_typ.delete(); it_b0.delete(); it_b1.delete();
  endtask

  task automatic add_item(input bit t, input logic [7:0] b0, input logic [7:0] b1);
    it_typ.push_back(t); it_b0.push_back(b0); it_b1.push_back(b1);
  endtask

  task automatic send_stream();
    foreach (sb[i]) send_byte(sb[i][7:0], sb[i][8]);
    sb.delete();
    for (int c = 0; c < CYC_MAX && done_cnt < done_exp; c++) begin @(posedge clock); #1; end
    @(posedge clock); #1;
    chk("parse_done_count", 32'(done_cnt), 32'(done_exp));
    chk("items_outstanding", 32'(exp_q.size()), 32'd0);
    chk("format_error", 32'(format_error), 32'(err_exp));
`ifdef LZRW1_PARSER_STATS_EN
    chk("literal_count", literal_count, lit_exp);
    chk("copy_count", copy_count, cp_exp);
`endif
  endtask

  task automatic scenario_literals();
    add_item(0, 8'h41, 8'h00);
    add_item(1, 8'h10, 8'h03);
    add_item(0, 8'h42, 8'h00);
    build(0, 0, 0);
    send_stream();
  endtask

  initial begin
    #2;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ctrl", 32'(control_word_out), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_ready", 32'(byte_in_ready), 32'd0);
    chk("rst_parse_done", 32'(parse_done), 32'd0);
    chk("rst_format_error", 32'(format_error), 32'd0);
    #21 reset = 1'b1;
    @(posedge clock); #1;

    // Literal / copy / literal stream.
    scenario_literals();

    // Control word wrap: 16 literals then a second control word.
    for (int i = 0; i < 16; i++) add_item(0, 8'(8'h61 + i), 8'h00);
    add_item(1, 8'h20, 8'h05);
    build(0, 0, 0);
    send_stream();

    // Truncated copy: no item, sticky error.
    add_item(1, 8'h30, 8'h00);
    build(2, 0, 0);
    send_stream();

    // Back-pressure: 20 cycles of busy with an item presented.
    busy_hold = 1'b1;
    add_item(0, 8'h55, 8'h00);
    build(0, 0, 0);
    fork
      send_stream();
      begin
        for (int c = 0; c < CYC_MAX && !data_out_valid; c++) @(negedge clock);
        chk("bp_presented", 32'(data_out_valid), 32'd1);
        repeat (20) begin
          @(negedge clock);
          chk("bp_still_valid", 32'(data_out_valid), 32'd1);
        end
        busy_hold = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("bp_valid_first_free", 32'(data_out_valid), 32'd1);
        @(negedge clock);
        chk("bp_accepted_gap", 32'(data_out_valid), 32'd0);
      end
    join

    // Randomized streams.
    rnd_busy = 1'b1; rnd_gap = 1'b1;
    for (int s = 0; s < 30; s++) begin
      int n, mode, r;
      n = ($urandom % 4 == 0) ? CWB * $urandom_range(0, 2) : $urandom_range(1, 40);
      r = $urandom % 4;
      mode = (r == 0) ? 2 : ((r == 1 && n % CWB == 0) ? 1 : 0);
      if (mode == 0 && n == 0) mode = 1;
      for (int i = 0; i < n; i++) add_item($urandom % 2, 8'($urandom), 8'($urandom));
      if (mode == 2) add_item(1, 8'($urandom), 8'h00);
      build(mode, $urandom_range(1, CWB / 8), 1);
      send_stream();
    end

    // Reset mid-copy.
    rnd_busy = 1'b0; rnd_gap = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_ctrl", 32'(control_word_out), 32'd0);
    chk("mid_rst_valid", 32'(data_out_valid), 32'd0);
    chk("mid_rst_ready", 32'(byte_in_ready), 32'd0);
    chk("mid_rst_parse_done", 32'(parse_done), 32'd0);
    chk("mid_rst_format_error", 32'(format_error), 32'd0);
    exp_q.delete(); done_cnt = 0; done_exp = 0; err_exp = 1'b0; lit_exp = 0; cp_exp = 0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    scenario_literals();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
